// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param: parametrised memory-game controller.
// Stores a growing one-hot move sequence, replays it on the LEDs and checks the player.
module jogo_memoria_param #(
    parameter int          N_BOTOES   = 4,
    parameter int          N_RODADAS  = 16,
    parameter int          TIMEOUT    = 3000,
    parameter int          LED_CYCLES = 500,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         iniciar,
    input  logic                         modo,
    input  logic [N_BOTOES-1:0]          botoes,
    output logic [N_BOTOES-1:0]          leds,
    output logic                         pronto,
    output logic                         ganhou,
    output logic                         perdeu,
    output logic                         timeout,
    output logic [$clog2(N_RODADAS)-1:0] rodada,
    output logic [3:0]                   db_estado,
    output logic [N_BOTOES-1:0]          db_jogada
);

    localparam int RW = $clog2(N_RODADAS);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LW = (LED_CYCLES > 1) ? $clog2(LED_CYCLES) : 1;
    localparam logic [N_BOTOES-1:0] UM = N_BOTOES'(1);

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        PREPARACAO   = 4'd1,
        GERA         = 4'd2,
        GRAVA_ESPERA = 4'd3,
        GRAVA        = 4'd4,
        MOSTRA       = 4'd5,
        MOSTRA_APAGA = 4'd6,
        ESPERA       = 4'd7,
        COMPARA      = 4'd8,
        FIM_GANHOU   = 4'd9,
        FIM_PERDEU   = 4'd10
    } estado_t;

    estado_t              estado, estado_n;
    logic [RW-1:0]        rodada_n, endereco, endereco_n;
    logic [TW-1:0]        cnt_to, cnt_to_n;
    logic [LW-1:0]        cnt_led, cnt_led_n;
    logic [15:0]          lfsr;
    logic                 tem_q, tem_jogada, borda, one_hot;
    logic [N_BOTOES-1:0]  jogada, jogada_n;
    logic                 modo_q, modo_n;
    logic                 to_flag, to_flag_n;
    logic                 we;
    logic [N_BOTOES-1:0]  wdata, ram_rd, ram_rd_n, gen_mov;
    logic                 to_fim, led_fim;
    logic [N_BOTOES-1:0]  mem [N_RODADAS];

    assign tem_jogada = |botoes;
    assign borda      = tem_jogada & ~tem_q;
    assign one_hot    = tem_jogada && ((botoes & (botoes - UM)) == '0);
    assign gen_mov    = UM << (lfsr[7:0] % 8'(N_BOTOES));
    assign to_fim     = (cnt_to == TW'(TIMEOUT - 1));
    assign led_fim    = (cnt_led == LW'(LED_CYCLES - 1));
    assign ram_rd     = mem[endereco];

    // Forward the word being written so a round-0 replay shows it at once
    assign ram_rd_n = (we && (rodada == endereco_n)) ? wdata : mem[endereco_n];

    always_comb begin
        estado_n   = estado;
        rodada_n   = rodada;
        endereco_n = endereco;
        cnt_to_n   = '0;
        cnt_led_n  = '0;
        jogada_n   = jogada;
        modo_n     = modo_q;
        to_flag_n  = to_flag;
        we         = 1'b0;
        wdata      = jogada;
        case (estado)
            INICIAL, FIM_GANHOU, FIM_PERDEU: begin
                if (iniciar) begin
                    estado_n   = PREPARACAO;
                    modo_n     = modo;
                    rodada_n   = '0;
                    endereco_n = '0;
                    to_flag_n  = 1'b0;
                    jogada_n   = '0;
                end
            end
            PREPARACAO: begin
                estado_n = modo_q ? GRAVA_ESPERA : GERA;
            end
            GERA: begin
                we       = 1'b1;
                wdata    = gen_mov;
                estado_n = MOSTRA;
            end
            GRAVA_ESPERA: begin
                if (borda && one_hot) begin
                    jogada_n = botoes;
                    estado_n = GRAVA;
                end else if (to_fim) begin
                    to_flag_n = 1'b1;
                    estado_n  = FIM_PERDEU;
                end else begin
                    cnt_to_n = cnt_to + 1'b1;
                end
            end
            GRAVA: begin
                we       = 1'b1;
                estado_n = MOSTRA;
            end
            MOSTRA: begin
                if (led_fim) estado_n = MOSTRA_APAGA;
                else cnt_led_n = cnt_led + 1'b1;
            end
            MOSTRA_APAGA: begin
                if (!led_fim) begin
                    cnt_led_n = cnt_led + 1'b1;
                end else if (endereco == rodada) begin
                    endereco_n = '0;
                    estado_n   = ESPERA;
                end else begin
                    endereco_n = endereco + 1'b1;
                    estado_n   = MOSTRA;
                end
            end
            ESPERA: begin
                if (borda) begin
                    jogada_n = botoes;
                    estado_n = COMPARA;
                end else if (to_fim) begin
                    to_flag_n = 1'b1;
                    estado_n  = FIM_PERDEU;
                end else begin
                    cnt_to_n = cnt_to + 1'b1;
                end
            end
            COMPARA: begin
                if (jogada != ram_rd) begin
                    estado_n = FIM_PERDEU;
                end else if (endereco != rodada) begin
                    endereco_n = endereco + 1'b1;
                    estado_n   = ESPERA;
                end else if (rodada == RW'(N_RODADAS - 1)) begin
                    estado_n = FIM_GANHOU;
                end else begin
                    rodada_n   = rodada + 1'b1;
                    endereco_n = '0;
                    estado_n   = modo_q ? GRAVA_ESPERA : GERA;
                end
            end
            default: estado_n = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            rodada   <= '0;
            endereco <= '0;
            cnt_to   <= '0;
            cnt_led  <= '0;
            lfsr     <= LFSR_SEED;
            tem_q    <= 1'b0;
            jogada   <= '0;
            modo_q   <= 1'b0;
            to_flag  <= 1'b0;
            leds     <= '0;
        end else begin
            estado   <= estado_n;
            rodada   <= rodada_n;
            endereco <= endereco_n;
            cnt_to   <= cnt_to_n;
            cnt_led  <= cnt_led_n;
            lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            tem_q    <= tem_jogada;
            jogada   <= jogada_n;
            modo_q   <= modo_n;
            to_flag  <= to_flag_n;
            leds     <= (estado_n == MOSTRA) ? ram_rd_n : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (we) mem[rodada] <= wdata;
    end

    assign pronto    = (estado == FIM_GANHOU) || (estado == FIM_PERDEU);
    assign ganhou    = (estado == FIM_GANHOU);
    assign perdeu    = (estado == FIM_PERDEU);
    assign timeout   = (estado == FIM_PERDEU) && to_flag;
    assign db_estado = estado;
    assign db_jogada = jogada;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// tb_jogo_memoria_param: directed bench for the memory-game controller.
// Drives inputs and samples outputs on the falling clock edge.
module tb_jogo_memoria_param;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       modo = 1'b0;
    logic [3:0] botoes = 4'd0;
    logic [3:0] leds;
    logic       pronto, ganhou, perdeu, timeout;
    logic [1:0] rodada;
    logic [3:0] db_estado;
    logic [3:0] db_jogada;

    int total = 0;
    int bad = 0;

    logic [3:0]  seq [4];
    logic [15:0] lm;

    typedef struct {
        logic [3:0] mov;
        logic [3:0] est;
        logic [1:0] rod;
    } rnd_t;
    rnd_t tab [4];

    jogo_memoria_param #(
        .N_BOTOES(4), .N_RODADAS(4), .TIMEOUT(100), .LED_CYCLES(4), .LFSR_SEED(16'hACE1)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo),
        .botoes(botoes), .leds(leds), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .timeout(timeout), .rodada(rodada),
        .db_estado(db_estado), .db_jogada(db_jogada)
    );

    always #5 clock = ~clock;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11
    always @(posedge clock or negedge reset) begin
        if (!reset) lm <= 16'hACE1;
        else lm <= {lm[14:0], lm[15] ^ lm[13] ^ lm[12] ^ lm[10]};
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", nm, act, req);
        end
    endtask

    task automatic wait_state(input logic [3:0] st, input int budget);
        int n = 0;
        while (db_estado !== st && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("wait_state", 32'(db_estado), 32'(st));
    endtask

    task automatic replay(input int r, input int rel);
        int errs = 0;
        logic [3:0] ev;
        logic [3:0] es;
        for (int c = 0; c < 8 * (r + 1); c++) begin
            if (c == rel) botoes = 4'd0;
            ev = ((c % 8) < 4) ? seq[c / 8] : 4'd0;
            es = ((c % 8) < 4) ? 4'd5 : 4'd6;
            if (leds !== ev || db_estado !== es) errs++;
            @(negedge clock);
        end
        chk("replay", 32'(errs), 32'd0);
        chk("espera_after_replay", 32'(db_estado), 32'd7);
    endtask

    task automatic record(input logic [3:0] mov, input int r, input int rel);
        wait_state(4'd3, 300);
        seq[r] = mov;
        botoes = mov;
        @(negedge clock);
        chk("grava", 32'(db_estado), 32'd4);
        @(negedge clock);
        replay(r, rel);
    endtask

    task automatic gen(input int r);
        @(negedge clock);
        chk("gera", 32'(db_estado), 32'd2);
        seq[r] = 4'b0001 << (lm[7:0] % 8'd4);
        @(negedge clock);
        replay(r, -1);
    endtask

    task automatic play_round(input int r);
        for (int i = 0; i <= r; i++) begin
            botoes = seq[i];
            if (i < r) begin
                repeat (5) @(negedge clock);
                botoes = 4'd0;
                chk("espera_mid", 32'(db_estado), 32'd7);
                repeat (10) @(negedge clock);
            end else begin
                @(negedge clock);
                chk("compara", 32'(db_estado), 32'd8);
                botoes = 4'd0;
            end
        end
    endtask

    task automatic start(input logic m);
        modo = m;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        chk("prep_state", 32'(db_estado), 32'd1);
        chk("prep_out", 32'({pronto, ganhou, perdeu, timeout}), 32'd0);
        chk("prep_rodada", 32'(rodada), 32'd0);
        chk("prep_jogada", 32'(db_jogada), 32'd0);
    endtask

    initial begin
        int n;
        logic [3:0] mv;
        tab[0] = '{mov: 4'b0001, est: 4'd3, rod: 2'd1};
        tab[1] = '{mov: 4'b0010, est: 4'd3, rod: 2'd2};
        tab[2] = '{mov: 4'b0100, est: 4'd3, rod: 2'd3};
        tab[3] = '{mov: 4'b1000, est: 4'd9, rod: 2'd3};

        // Reset and idle
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        chk("idle_state", 32'(db_estado), 32'd0);
        chk("idle_leds", 32'(leds), 32'd0);
        chk("idle_out", 32'({pronto, ganhou, perdeu, timeout}), 32'd0);
        chk("idle_rodada", 32'(rodada), 32'd0);

        // Win in player-recorded mode
        start(1'b1);
        for (int r = 0; r < 4; r++) begin
            record(tab[r].mov, r, 3);
            play_round(r);
            @(negedge clock);
            chk("round_state", 32'(db_estado), 32'(tab[r].est));
            chk("round_rodada", 32'(rodada), 32'(tab[r].rod));
        end
        chk("win_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'b1100);

        // Wrong move
        start(1'b1);
        record(4'b0001, 0, 3);
        botoes = 4'b0010;
        @(negedge clock);
        chk("wrong_compara", 32'(db_estado), 32'd8);
        @(negedge clock);
        botoes = 4'd0;
        chk("wrong_state", 32'(db_estado), 32'd10);
        chk("wrong_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'b1010);
        chk("wrong_jogada", 32'(db_jogada), 32'b0010);

        // Timeout in espera
        start(1'b1);
        record(4'b0001, 0, 3);
        n = 0;
        while (db_estado === 4'd7 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("to_cycles", 32'(n), 32'd100);
        chk("to_state", 32'(db_estado), 32'd10);
        chk("to_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'b1011);

        // Multi-bit input: ignored while recording, wrong while repeating
        start(1'b1);
        wait_state(4'd3, 10);
        botoes = 4'b0011;
        repeat (3) @(negedge clock);
        chk("inv_grava_espera", 32'(db_estado), 32'd3);
        botoes = 4'd0;
        @(negedge clock);
        record(4'b0001, 0, 3);
        botoes = 4'b0011;
        repeat (2) @(negedge clock);
        botoes = 4'd0;
        chk("inv_espera_state", 32'(db_estado), 32'd10);
        chk("inv_espera_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'b1010);
        chk("inv_jogada", 32'(db_jogada), 32'b0011);

        // Button held through replay is not a new move
        start(1'b1);
        record(4'b0001, 0, -1);
        n = 0;
        while (db_estado === 4'd7 && n < 300) begin
            @(negedge clock);
            n++;
        end
        botoes = 4'd0;
        chk("held_cycles", 32'(n), 32'd100);
        chk("held_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'b1011);

        // Win in LFSR mode
        start(1'b0);
        for (int r = 0; r < 4; r++) begin
            gen(r);
            play_round(r);
        end
        @(negedge clock);
        chk("lfsr_win_state", 32'(db_estado), 32'd9);
        chk("lfsr_win_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'b1100);
        chk("lfsr_win_rodada", 32'(rodada), 32'd3);

        // Restart, then reset in the middle of the replay
        start(1'b0);
        @(negedge clock);
        chk("restart_gera", 32'(db_estado), 32'd2);
        mv = 4'b0001 << (lm[7:0] % 8'd4);
        repeat (2) @(negedge clock);
        chk("restart_led", 32'(leds), 32'(mv));
        reset = 1'b0;
        #1;
        chk("abort_state", 32'(db_estado), 32'd0);
        chk("abort_leds", 32'(leds), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("post_abort_state", 32'(db_estado), 32'd0);
        chk("post_abort_leds", 32'(leds), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jogo_memoria_param.md
# jogo_memoria_param

Parametrised memory-game controller: stores a growing sequence of one-hot button moves, replays it on the LEDs each round, checks the player's repetition and declares win, loss or timeout. Next generation of the fixed 4-button/16-round game. It adds:
- configurable button count, round count, timeout and LED display time;
- a runtime mode selecting player-recorded moves or LFSR-generated moves.

It sits between the board buttons/LEDs and the top-level display/debug logic.

## Interface
- N_BOTOES, 4: number of buttons/LEDs (2..8).
- N_RODADAS, 16: rounds to win (2..64); RW = clog2(N_RODADAS).
- TIMEOUT, 3000: clock cycles allowed per player move.
- LED_CYCLES, 500: cycles each replayed move is lit, then the same number dark.
- LFSR_SEED, 16'hACE1: reset value of the 16-bit Fibonacci LFSR (taps 16,14,13,11).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start request, level-sampled.
- modo  in  1  0 = LFSR-generated moves, 1 = player-recorded moves; sampled only when leaving inicial/end states.
- botoes  in  N_BOTOES  raw (already synchronised) buttons.
- leds  out  N_BOTOES  replay display, registered.
- pronto  out  1  game over (won or lost).
- ganhou  out  1  won.
- perdeu  out  1  lost by wrong move or timeout.
- timeout  out  1  loss was caused by timeout.
- rodada  out  RW  current round index, 0-based.
- db_estado  out  4  state encoding.
- db_jogada  out  N_BOTOES  last registered move.

## Operation
- Sequence RAM: N_RODADAS x N_BOTOES, synchronous write, asynchronous read. Address comes from a replay/compare counter `endereco` (RW bits).
- Move detection: `tem_jogada` = |botoes. Its 0->1 edge registers botoes into `jogada`.
  - A move with more than one bit set is registered as-is and is always wrong.
  - A move in modo 1 recording with more than one bit set is ignored: stay in grava_espera.
- LFSR:
  - Free-running every cycle from reset.
  - Generated move = one-hot of (lfsr[7:0] mod N_BOTOES).
- States (db_estado):
  - inicial 0: all game outputs 0. iniciar=1 -> preparacao.
  - preparacao 1: clears rodada, endereco, timeout counter and flags; latches modo. Next state is grava_espera in modo 1, gera in modo 0.
  - gera 2: writes LFSR move at address rodada -> mostra.
  - grava_espera 3: waits for a move edge. A valid one-hot move -> grava. The timeout counter runs here too.
  - grava 4: writes jogada at address rodada -> mostra.
  - mostra 5: leds = RAM[endereco] for LED_CYCLES -> mostra_apaga.
  - mostra_apaga 6: leds = 0 for LED_CYCLES. If endereco == rodada, clear endereco -> espera; else endereco++ -> mostra.
  - espera 7: waits for a move edge -> compara. If the timeout counter reaches TIMEOUT-1 -> fim_perdeu with timeout=1.
  - compara 8: if jogada != RAM[endereco] -> fim_perdeu. Otherwise:
    - if endereco != rodada: endereco++, clear timeout counter -> espera;
    - else if rodada == N_RODADAS-1 -> fim_ganhou;
    - else rodada++, endereco=0 -> gera (modo 0) or grava_espera (modo 1).
  - fim_ganhou 9: pronto=1, ganhou=1.
  - fim_perdeu 10: pronto=1, perdeu=1, timeout as set.
  - Both end states hold until iniciar=1, then -> preparacao.
- Arithmetic: all counters wrap-free by construction; the timeout counter saturates at TIMEOUT-1.

## Timing
- Reset (asynchronous, while reset=0):
  - state=inicial, all outputs 0;
  - rodada, endereco and counters 0; lfsr=LFSR_SEED;
  - RAM contents undefined.
  - Reset mid-game aborts immediately; the first rising edge after release is in inicial.
- iniciar high at edge t -> preparacao at t+1 -> gera/grava_espera at t+2.
- Move edge sampled at edge t -> jogada valid and state compara at t+1 -> verdict state at t+2.
- Holding a button produces exactly one move. A new move requires botoes to return to 0 for at least 1 cycle.
- Replay: each sequence entry occupies exactly 2*LED_CYCLES cycles. Round k replay lasts (k+1)*2*LED_CYCLES.
- Timeout: TIMEOUT cycles in espera/grava_espera with no move edge -> fim_perdeu on the following edge.
- A move edge arriving in the same cycle that the timeout is reached counts as the move: the timeout is not asserted.
- Buttons pressed during mostra/mostra_apaga/compara are ignored. The edge detector still tracks them, so a button held into espera is not a new move.

## Test plan
Common parameters: N_BOTOES=4, N_RODADAS=4, TIMEOUT=100, LED_CYCLES=4.
- Reset/idle: reset=0 for 2 cycles, release, wait 10 cycles -> db_estado=0, leds=0, pronto=ganhou=perdeu=timeout=0.
- Win in modo 1: record 0001, then repeat and append in turn 0010, 0100, 1000, each press 5 cycles, gaps 10 cycles. Required:
  - each replay shows the stored prefix, 4 cycles per LED;
  - after the 4th repetition, ganhou=1, pronto=1, rodada=3.
- Wrong move: modo 1, record 0001, replay, press 0010 -> perdeu=1, timeout=0, db_jogada=0010, db_estado=10.
- Timeout: modo 1, record 0001, after replay press nothing -> exactly 100 cycles into espera, perdeu=1, timeout=1.
- Invalid and held input:
  - 0011 in grava_espera is ignored, state stays 3;
  - 0011 in espera gives perdeu=1;
  - button held from grava through replay into espera gives no move and still times out.
- Modo 0 and restart: LFSR game, bench reference-models the LFSR and plays the correct moves -> ganhou=1. Then iniciar=1 -> preparacao, outputs cleared. Assert reset mid-replay -> immediate return to inicial with leds=0.
